// File: rtl/inst_dispatch_if.sv
// Instruction channel into inst_dispatch: a valid/ready handshake carrying one instruction word.
// The master drives instructions in; the slave is the dispatcher.
interface inst_dispatch_if #(
  parameter int unsigned InstWidth = 28
);
  logic [InstWidth-1:0] inst;
  logic                 inst_valid;
  logic                 inst_ready;

  modport master (output inst, output inst_valid, input inst_ready);
  modport slave  (input inst, input inst_valid, output inst_ready);
endinterface

// File: rtl/inst_dispatch.sv
// Instruction dispatcher: buffers instructions, expands LOAD/STORE into address beats and issues
// compute commands. Define INST_PERF_CNT_EN to add the retired_cnt_o instruction counter.
module inst_dispatch #(
  parameter int unsigned InstWidth = 28,
  parameter int unsigned AddrWidth = 12,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  inst_dispatch_if.slave       inst_bus,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [1:0]           mem_port_o,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [2:0]           cmd_op_o,
  output logic [3:0]           cmd_a_o,
  output logic [3:0]           cmd_b_o,
  output logic [3:0]           cmd_c_o,
  output logic [1:0]           cmd_mode_o,
  input  logic                 cmd_done_i,
  output logic                 busy_o,
  output logic                 illegal_o
`ifdef INST_PERF_CNT_EN
  ,
  output logic [31:0]          retired_cnt_o
`endif
);

  localparam int unsigned PtrW = $clog2(FifoDepth);

  typedef enum logic [1:0] {StIdle, StBurst, StCmd, StWait} state_e;

  // FIFO with one extra pointer bit to tell full from empty.
  logic [InstWidth-1:0] fifo_q [FifoDepth];
  logic [PtrW:0]        wr_ptr_q, rd_ptr_q;
  logic                 full, empty, push, pop;
  logic [InstWidth-1:0] head;
  logic [2:0]           op;
  logic                 unused_head;

  state_e               state_q;
  logic [5:0]           beats_q;
  logic                 mem_valid_q, mem_we_q;
  logic [AddrWidth-1:0] mem_addr_q;
  logic [1:0]           mem_port_q;
  logic                 cmd_valid_q;
  logic [2:0]           cmd_op_q;
  logic [3:0]           cmd_a_q, cmd_b_q, cmd_c_q;
  logic [1:0]           cmd_mode_q;
  logic                 illegal_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign push  = inst_bus.inst_valid && !full;
  assign pop   = (state_q == StIdle) && !empty;
  assign head  = fifo_q[rd_ptr_q[PtrW-1:0]];
  assign op    = head[27:25];
  assign unused_head = ^head[4:0];

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q[PtrW-1:0]] <= inst_bus.inst;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      beats_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_port_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_a_q     <= '0;
      cmd_b_q     <= '0;
      cmd_c_q     <= '0;
      cmd_mode_q  <= '0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            case (op)
              3'b000, 3'b001: begin
                // Zero-length transfers retire without touching the memory bus.
                if (head[12:7] != 6'd0) begin
                  state_q     <= StBurst;
                  beats_q     <= head[12:7];
                  mem_valid_q <= 1'b1;
                  mem_we_q    <= op[0];
                  mem_addr_q  <= AddrWidth'(head[24:13]);
                  mem_port_q  <= head[6:5];
                end
              end
              3'b100, 3'b101, 3'b110: begin
                state_q     <= StCmd;
                cmd_valid_q <= 1'b1;
                cmd_op_q    <= op;
                cmd_a_q     <= head[24:21];
                cmd_b_q     <= head[20:17];
                cmd_c_q     <= head[16:13];
                cmd_mode_q  <= head[12:11];
              end
              default: illegal_q <= 1'b1;
            endcase
          end
        end
        StBurst: begin
          if (mem_ready_i) begin
            if (beats_q == 6'd1) begin
              mem_valid_q <= 1'b0;
              state_q     <= StIdle;
            end else begin
              beats_q    <= beats_q - 6'd1;
              mem_addr_q <= mem_addr_q + 1'b1;
            end
          end
        end
        StCmd: begin
          if (cmd_ready_i) begin
            cmd_valid_q <= 1'b0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (cmd_done_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef INST_PERF_CNT_EN
  logic        retire;
  logic [31:0] retired_cnt_q;

  assign retire = (pop && (op[2:1] == 2'b00) && (head[12:7] == 6'd0)) ||
                  ((state_q == StBurst) && mem_ready_i && (beats_q == 6'd1)) ||
                  ((state_q == StWait) && cmd_done_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) retired_cnt_q <= '0;
    else if (retire) retired_cnt_q <= retired_cnt_q + 32'd1;
  end

  assign retired_cnt_o = retired_cnt_q;
`endif

  assign inst_bus.inst_ready = !full;
  assign mem_valid_o = mem_valid_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_port_o  = mem_port_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_op_o    = cmd_op_q;
  assign cmd_a_o     = cmd_a_q;
  assign cmd_b_o     = cmd_b_q;
  assign cmd_c_o     = cmd_c_q;
  assign cmd_mode_o  = cmd_mode_q;
  assign busy_o      = !empty || (state_q != StIdle);
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_inst_dispatch.sv
// Directed bench for inst_dispatch: bursts, address wrap, compute handshake, FIFO backpressure,
// illegal opcodes and mid-burst reset.
module tb_inst_dispatch;
  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_valid, mem_ready, mem_we;
  logic [11:0] mem_addr;
  logic [1:0]  mem_port;
  logic        cmd_valid, cmd_ready, cmd_done;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_a, cmd_b, cmd_c;
  logic [1:0]  cmd_mode;
  logic        busy, illegal;
`ifdef INST_PERF_CNT_EN
  logic [31:0] retired_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] beats[$];
  logic [11:0] exp_beats[8];

  inst_dispatch_if #(.InstWidth(28)) ibus ();

  inst_dispatch dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .inst_bus    (ibus),
    .mem_valid_o (mem_valid),
    .mem_ready_i (mem_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_port_o  (mem_port),
    .cmd_valid_o (cmd_valid),
    .cmd_ready_i (cmd_ready),
    .cmd_op_o    (cmd_op),
    .cmd_a_o     (cmd_a),
    .cmd_b_o     (cmd_b),
    .cmd_c_o     (cmd_c),
    .cmd_mode_o  (cmd_mode),
    .cmd_done_i  (cmd_done),
    .busy_o      (busy),
    .illegal_o   (illegal)
`ifdef INST_PERF_CNT_EN
    ,
    .retired_cnt_o (retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rstn && mem_valid && mem_ready) beats.push_back(mem_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] mem_inst(input logic [2:0] op, input logic [11:0] a,
                                           input logic [5:0] len, input logic [1:0] port);
    return {op, a, len, port, 5'd0};
  endfunction

  function automatic logic [27:0] cmp_inst(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b, input logic [3:0] c,
                                           input logic [1:0] mode);
    return {op, a, b, c, mode, 11'd0};
  endfunction

  // Waits (bounded) for ready, then holds valid for exactly one accepting edge.
  task automatic push(input logic [27:0] w);
    int t = 0;
    ibus.inst       = w;
    ibus.inst_valid = 1'b1;
    while (!ibus.inst_ready && t < 50) begin
      step();
      t++;
    end
    chk("push_ready", {31'd0, ibus.inst_ready}, 32'd1);
    step();
    ibus.inst_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      step();
      t++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    ibus.inst = '0;
    ibus.inst_valid = 1'b0;
    mem_ready = 1'b0;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    step();
    step();
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_inst_ready", {31'd0, ibus.inst_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", {20'd0, mem_addr}, 32'd0);
    rstn = 1'b1;
    step();

    // 1: LOAD 100 len 4, always ready
    mem_ready = 1'b1;
    push(mem_inst(3'b000, 12'd100, 6'd4, 2'd0));
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", {31'd0, mem_valid}, 32'd1);
      chk("t1_addr", {20'd0, mem_addr}, 32'(100 + i));
      chk("t1_we", {31'd0, mem_we}, 32'd0);
      step();
    end
    chk("t1_end_valid", {31'd0, mem_valid}, 32'd0);
    chk("t1_end_busy", {31'd0, busy}, 32'd0);

    // 2: STORE 0xFFE len 3 port 2 with stalls, address wraps
    mem_ready = 1'b0;
    push(mem_inst(3'b001, 12'hFFE, 6'd3, 2'd2));
    step();
    chk("t2_addr0", {20'd0, mem_addr}, 32'hFFE);
    chk("t2_we", {31'd0, mem_we}, 32'd1);
    chk("t2_port", {30'd0, mem_port}, 32'd2);
    step();
    chk("t2_hold0", {20'd0, mem_addr}, 32'hFFE);
    mem_ready = 1'b1;
    step();
    chk("t2_addr1", {20'd0, mem_addr}, 32'hFFF);
    mem_ready = 1'b0;
    step();
    chk("t2_hold1", {20'd0, mem_addr}, 32'hFFF);
    chk("t2_valid_held", {31'd0, mem_valid}, 32'd1);
    mem_ready = 1'b1;
    step();
    chk("t2_addr2_wrap", {20'd0, mem_addr}, 32'h000);
    chk("t2_port_held", {30'd0, mem_port}, 32'd2);
    step();
    chk("t2_end_valid", {31'd0, mem_valid}, 32'd0);
    chk("t2_end_busy", {31'd0, busy}, 32'd0);

    // 3: compute, a queued LOAD must wait for cmd_done
    mem_ready = 1'b0;
    push(cmp_inst(3'b100, 4'd1, 4'd2, 4'd3, 2'd0));
    ibus.inst = mem_inst(3'b000, 12'd5, 6'd1, 2'd1);
    ibus.inst_valid = 1'b1;
    step();
    ibus.inst_valid = 1'b0;
    chk("t3_cmd_valid", {31'd0, cmd_valid}, 32'd1);
    chk("t3_op", {29'd0, cmd_op}, 32'd4);
    chk("t3_a", {28'd0, cmd_a}, 32'd1);
    chk("t3_b", {28'd0, cmd_b}, 32'd2);
    chk("t3_c", {28'd0, cmd_c}, 32'd3);
    step();
    chk("t3_hold_valid", {31'd0, cmd_valid}, 32'd1);
    chk("t3_hold_fields", {20'd0, cmd_a, cmd_b, cmd_c}, 32'h123);
    cmd_ready = 1'b1;
    cmd_done  = 1'b1;
    step();
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    chk("t3_cmd_drop", {31'd0, cmd_valid}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("t3_wait_no_mem", {31'd0, mem_valid}, 32'd0);
    end
    chk("t3_wait_busy", {31'd0, busy}, 32'd1);
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    chk("t3_done_no_mem", {31'd0, mem_valid}, 32'd0);
    step();
    chk("t3_next_valid", {31'd0, mem_valid}, 32'd1);
    chk("t3_next_addr", {20'd0, mem_addr}, 32'd5);
    mem_ready = 1'b1;
    step();
    chk("t3_end_busy", {31'd0, busy}, 32'd0);

    // 4: six pushes behind a stalled burst, FIFO fills at 4
    mem_ready = 1'b0;
    push(mem_inst(3'b000, 12'h200, 6'd2, 2'd1));
    step();
    chk("t4_burst_valid", {31'd0, mem_valid}, 32'd1);
    beats.delete();
    for (int k = 0; k < 4; k++) begin
      chk("t4_ready_fill", {31'd0, ibus.inst_ready}, 32'd1);
      ibus.inst = mem_inst(3'b000, 12'(16 + k), 6'd1, 2'd0);
      ibus.inst_valid = 1'b1;
      step();
    end
    ibus.inst_valid = 1'b0;
    chk("t4_full_ready", {31'd0, ibus.inst_ready}, 32'd0);
    chk("t4_stall_addr", {20'd0, mem_addr}, 32'h200);
    mem_ready = 1'b1;
    push(mem_inst(3'b000, 12'h014, 6'd1, 2'd0));
    push(mem_inst(3'b000, 12'h015, 6'd1, 2'd0));
    wait_idle();
    exp_beats = '{12'h200, 12'h201, 12'h010, 12'h011, 12'h012, 12'h013, 12'h014, 12'h015};
    chk("t4_beat_count", beats.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t4_order", (i < beats.size()) ? {20'd0, beats[i]} : 32'hDEAD, {20'd0, exp_beats[i]});
    end

    // 5: illegal opcode, then zero-length LOAD
    beats.delete();
    push({3'b011, 25'd0});
    step();
    chk("t5_illegal_pulse", {31'd0, illegal}, 32'd1);
    push(mem_inst(3'b000, 12'h300, 6'd0, 2'd0));
    chk("t5_illegal_clear", {31'd0, illegal}, 32'd0);
    step();
    chk("t5_no_mem", {31'd0, mem_valid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_no_beats", beats.size(), 32'd0);
`ifdef INST_PERF_CNT_EN
    chk("t5_retired", retired_cnt, 32'd12);
`endif

    // 6: reset during the 2nd beat of a long burst, with another inst queued
    mem_ready = 1'b1;
    push(mem_inst(3'b000, 12'h300, 6'd8, 2'd0));
    push(mem_inst(3'b000, 12'h400, 6'd1, 2'd0));
    chk("t6_beat0", {20'd0, mem_addr}, 32'h300);
    step();
    chk("t6_beat1", {20'd0, mem_addr}, 32'h301);
    rstn = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("t6_rst_addr", {20'd0, mem_addr}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_ready", {31'd0, ibus.inst_ready}, 32'd1);
`ifdef INST_PERF_CNT_EN
    chk("t6_rst_retired", retired_cnt, 32'd0);
`endif
    step();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_no_replay", {31'd0, mem_valid}, 32'd0);
    end
    chk("t6_idle", {31'd0, busy}, 32'd0);
    push(mem_inst(3'b000, 12'h050, 6'd1, 2'd3));
    step();
    chk("t6_new_valid", {31'd0, mem_valid}, 32'd1);
    chk("t6_new_addr", {20'd0, mem_addr}, 32'h050);
    step();
    chk("t6_new_done", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
